// File: rtl/dsm_ctrl_pkg.sv
// Shared types and defaults for the NCO frequency-sweep controller.
`timescale 1ns/1ps
package dsm_ctrl_pkg;

  localparam int STEP_WIDTH_DEFAULT  = 32;
  localparam int DWELL_WIDTH_DEFAULT = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } sweep_state_t;

  // Run-mode portion of the latched sweep descriptor. The width-dependent
  // fields (start/stop/delta/dwell) live in parameterised registers in the top.
  typedef struct packed {
    logic loop_mode;
    logic dither;
    logic dir_up;
  } sweep_cfg_t;

endpackage

// File: rtl/dsm_dwell_timer.sv
// Loadable down-counter that measures how long each sweep step is held.
// A load value of 0 behaves like 1, so every step lasts at least one cycle.
`timescale 1ns/1ps
module dsm_dwell_timer #(
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   expire
);

  localparam logic [DWELL_WIDTH-1:0] ONE = DWELL_WIDTH'(1);

  logic [DWELL_WIDTH-1:0] count;

  // Count down the remaining cycles of the current step; load restarts it at D-1.
  always_ff @(posedge aclk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (dwell == '0) ? '0 : dwell - ONE;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/dsm_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the NCO tuning word of dsm_core.
// Latches a descriptor on start, walks the step from start to stop with a
// clamp on the final step, and either finishes or restarts in loop mode.
`timescale 1ns/1ps
module dsm_sweep_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int STEP_WIDTH  = STEP_WIDTH_DEFAULT,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_stop_step,
  input  logic [STEP_WIDTH-1:0]  cfg_delta,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  input  logic                   cfg_dither,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  nco_step,
  output logic                   nco_step_enable,
  output logic                   dither_enable
);

  sweep_state_t            state, state_n;
  sweep_cfg_t              cfg_q;
  logic [STEP_WIDTH-1:0]   start_q, stop_q, delta_q;
  logic [DWELL_WIDTH-1:0]  dwell_q, load_val;
  logic [STEP_WIDTH-1:0]   cur_step, step_n, next_step;
  logic [STEP_WIDTH:0]     sum_up, diff_dn;
  logic                    latch, load, expire, done_n, is_final;

  dsm_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
    .aclk   (aclk),
    .rst    (rst),
    .load   (load),
    .dwell  (load_val),
    .expire (expire)
  );

  // Next tuning word in one extra bit so a carry or borrow shows up as a wrap,
  // which is clamped to stop just like overshooting stop.
  always_comb begin
    sum_up    = {1'b0, cur_step} + {1'b0, delta_q};
    diff_dn   = {1'b0, cur_step} - {1'b0, delta_q};
    next_step = stop_q;
    if (cfg_q.dir_up) begin
      if (!sum_up[STEP_WIDTH] && (sum_up[STEP_WIDTH-1:0] < stop_q))
        next_step = sum_up[STEP_WIDTH-1:0];
    end else begin
      if (!diff_dn[STEP_WIDTH] && (diff_dn[STEP_WIDTH-1:0] > stop_q))
        next_step = diff_dn[STEP_WIDTH-1:0];
    end
    is_final = (cur_step == stop_q) || (delta_q == '0);
  end

  // Sweep sequencing: accept start in IDLE, advance or finish on dwell expiry.
  always_comb begin
    state_n  = state;
    step_n   = cur_step;
    done_n   = 1'b0;
    latch    = 1'b0;
    load     = 1'b0;
    load_val = dwell_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          latch    = 1'b1;
          load     = 1'b1;
          load_val = cfg_dwell;
          step_n   = cfg_start_step;
          state_n  = DWELL;
        end
      end
      DWELL: begin
        if (abort) begin
          state_n = IDLE;
        end else if (expire) begin
          if (is_final) begin
            if (cfg_q.loop_mode) begin
              step_n = start_q;
              load   = 1'b1;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            step_n = next_step;
            load   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, current step, done pulse and the descriptor captured at start.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state    <= IDLE;
      cur_step <= '0;
      done     <= 1'b0;
      start_q  <= '0;
      stop_q   <= '0;
      delta_q  <= '0;
      dwell_q  <= '0;
      cfg_q    <= '0;
    end else begin
      state    <= state_n;
      cur_step <= step_n;
      done     <= done_n;
      if (latch) begin
        start_q         <= cfg_start_step;
        stop_q          <= cfg_stop_step;
        delta_q         <= cfg_delta;
        dwell_q         <= cfg_dwell;
        cfg_q.loop_mode <= cfg_loop;
        cfg_q.dither    <= cfg_dither;
        cfg_q.dir_up    <= (cfg_stop_step >= cfg_start_step);
      end
    end
  end

  assign busy            = (state == DWELL);
  assign nco_step_enable = busy;
  assign dither_enable   = busy & cfg_q.dither;
  assign nco_step        = cur_step;

endmodule

// File: tb/tb_dsm_sweep_ctrl.sv
// Self-checking bench for dsm_sweep_ctrl: a queue-based reference model of the
// per-cycle step sequence, checked every cycle, plus literal directed sweeps.
`timescale 1ns/1ps
module tb_dsm_sweep_ctrl;

  localparam int SW = 32;
  localparam int DW = 24;

  logic          aclk = 1'b0;
  logic          rst;
  logic [SW-1:0] cfg_start_step, cfg_stop_step, cfg_delta;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_loop, cfg_dither, start, abort;
  logic          busy, done, nco_step_enable, dither_enable;
  logic [SW-1:0] nco_step;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: queue holds the step value of every remaining cycle.
  bit          m_running = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_loop, m_dither;
  logic [31:0] m_hold = '0;
  logic [31:0] m_start, m_stop, m_delta;
  int          m_dwell;
  logic [31:0] m_q[$];

  logic [31:0] exp_up   [12];
  logic [31:0] exp_dn   [4];
  logic [31:0] exp_wrap [4];
  logic [31:0] exp_loop [7];

  always #5 aclk = ~aclk;

  dsm_sweep_ctrl #(.STEP_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
    .aclk            (aclk),
    .rst             (rst),
    .cfg_start_step  (cfg_start_step),
    .cfg_stop_step   (cfg_stop_step),
    .cfg_delta       (cfg_delta),
    .cfg_dwell       (cfg_dwell),
    .cfg_loop        (cfg_loop),
    .cfg_dither      (cfg_dither),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .nco_step        (nco_step),
    .nco_step_enable (nco_step_enable),
    .dither_enable   (dither_enable)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand the latched descriptor into one queue entry per enabled cycle.
  function automatic void fillRun();
    longint      cur, nxt, stop_l, delta_l;
    logic [31:0] steps[$];
    int          d;
    d       = (m_dwell == 0) ? 1 : m_dwell;
    cur     = longint'(m_start);
    stop_l  = longint'(m_stop);
    delta_l = longint'(m_delta);
    steps.push_back(m_start);
    while (!(cur == stop_l || delta_l == 0)) begin
      if (m_stop >= m_start) begin
        nxt = cur + delta_l;
        if (nxt > stop_l) nxt = stop_l;
      end else begin
        nxt = cur - delta_l;
        if (nxt < stop_l) nxt = stop_l;
      end
      cur = nxt;
      steps.push_back(cur[31:0]);
    end
    for (int i = 0; i < steps.size(); i++)
      for (int k = 0; k < d; k++)
        m_q.push_back(steps[i]);
  endfunction

  // Reference model advances one cycle per rising edge.
  always @(posedge aclk) begin
    if (rst) begin
      m_running = 1'b0;
      m_done    = 1'b0;
      m_hold    = '0;
      m_q.delete();
    end else if (m_running) begin
      m_done = 1'b0;
      if (abort) begin
        m_hold    = m_q[0];
        m_running = 1'b0;
        m_q.delete();
      end else begin
        m_hold = m_q.pop_front();
        if (m_q.size() == 0) begin
          if (m_loop) fillRun();
          else begin
            m_running = 1'b0;
            m_done    = 1'b1;
          end
        end
      end
    end else begin
      m_done = 1'b0;
      if (start && !abort) begin
        m_start   = cfg_start_step;
        m_stop    = cfg_stop_step;
        m_delta   = cfg_delta;
        m_dwell   = int'(cfg_dwell);
        m_loop    = cfg_loop;
        m_dither  = cfg_dither;
        fillRun();
        m_running = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge aclk) begin
    if (chk_en) begin
      checkOutput("busy", 32'(busy), 32'(m_running));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("nco_step_enable", 32'(nco_step_enable), 32'(m_running));
      checkOutput("dither_enable", 32'(dither_enable), 32'(m_running & m_dither));
      checkOutput("nco_step", nco_step, m_running ? m_q[0] : m_hold);
    end
  end

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] p, input logic [31:0] dl,
                               input logic [23:0] dw, input bit lp, input bit dt);
    cfg_start_step = s;
    cfg_stop_step  = p;
    cfg_delta      = dl;
    cfg_dwell      = dw;
    cfg_loop       = lp;
    cfg_dither     = dt;
    start          = 1'b1;
    @(negedge aclk);
    start          = 1'b0;
  endtask

  initial begin
    logic [31:0] s, p, dl;
    longint      pl;
    int unsigned span;
    int          abort_at, cyc;
    bit          lp;

    exp_up   = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
    exp_dn   = '{50, 30, 10, 5};
    exp_wrap = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp_loop = '{0, 1, 2, 0, 1, 2, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_start_step = '0; cfg_stop_step = '0; cfg_delta = '0;
    cfg_dwell = '0; cfg_loop = 1'b0; cfg_dither = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_step", nco_step, 0);
    checkOutput("reset_enable", 32'(nco_step_enable), 0);
    checkOutput("reset_dither", 32'(dither_enable), 0);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge aclk);

    // Up sweep, single mode
    applyStimulus(100, 130, 10, 3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("up_step", nco_step, exp_up[i]);
      checkOutput("up_busy", 32'(busy), 1);
      @(negedge aclk);
    end
    checkOutput("up_done", 32'(done), 1);
    checkOutput("up_busy_end", 32'(busy), 0);
    @(negedge aclk);
    checkOutput("up_done_pulse", 32'(done), 0);

    // Down sweep with clamp on final step, dwell 0 behaves as 1
    applyStimulus(50, 5, 20, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("down_step", nco_step, exp_dn[i]);
      @(negedge aclk);
    end
    checkOutput("down_done", 32'(done), 1);

    // Wrap guard near the top of the range
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_step", nco_step, exp_wrap[i]);
      @(negedge aclk);
    end
    checkOutput("wrap_done", 32'(done), 1);

    // Loop mode with dither, then abort together with start
    applyStimulus(0, 2, 1, 1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      checkOutput("loop_step", nco_step, exp_loop[i]);
      checkOutput("loop_dither", 32'(dither_enable), 1);
      @(negedge aclk);
    end
    start = 1'b1; abort = 1'b1; cfg_start_step = 99;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_enable", 32'(nco_step_enable), 0);
    checkOutput("abort_dither", 32'(dither_enable), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_step_hold", nco_step, 1);
    @(negedge aclk);
    checkOutput("abort_no_done", 32'(done), 0);

    // Start and cfg changes while busy are ignored; restart in first IDLE cycle
    applyStimulus(100, 130, 10, 3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("busy_start_step", nco_step, exp_up[i]);
      if (i == 4) begin
        start = 1'b1; cfg_start_step = 500; cfg_stop_step = 0;
        cfg_delta = 1; cfg_dwell = 7;
      end else begin
        start = 1'b0;
      end
      @(negedge aclk);
    end
    checkOutput("busy_start_done", 32'(done), 1);
    applyStimulus(7, 7, 0, 2, 1'b0, 1'b0);
    checkOutput("restart_step", nco_step, 7);
    checkOutput("restart_busy", 32'(busy), 1);
    @(negedge aclk);
    checkOutput("restart_step2", nco_step, 7);
    @(negedge aclk);
    checkOutput("restart_done", 32'(done), 1);

    // Reset mid-dwell
    applyStimulus(1000, 2000, 100, 5, 1'b1, 1'b1);
    repeat (2) @(negedge aclk);
    rst = 1'b1;
    @(negedge aclk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_step", nco_step, 0);
    checkOutput("rst_dither", 32'(dither_enable), 0);
    rst = 1'b0;
    @(negedge aclk);

    // Randomised runs checked by the model
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0:       s = $urandom;
        1:       s = $urandom_range(0, 200);
        default: s = 32'hFFFF_FFFF - $urandom_range(0, 200);
      endcase
      span = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) begin
        pl = longint'(s) + longint'(span);
        if (pl > 64'sh0000_0000_FFFF_FFFF) pl = 64'sh0000_0000_FFFF_FFFF;
      end else begin
        pl = longint'(s) - longint'(span);
        if (pl < 0) pl = 0;
      end
      p = pl[31:0];
      if ($urandom_range(0, 4) == 0) dl = 0;
      else if ($urandom_range(0, 1) == 1) dl = 32'(span / $urandom_range(1, 8) + 1);
      else dl = $urandom;
      lp = ($urandom_range(0, 2) == 0);
      applyStimulus(s, p, dl, 24'($urandom_range(0, 4)), lp, 1'($urandom_range(0, 1)));
      abort_at = lp ? $urandom_range(1, 80)
                    : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1);
      cyc = 0;
      while (m_running && cyc < 400) begin
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) begin
          cfg_start_step = $urandom; cfg_stop_step = $urandom;
          cfg_delta = $urandom; cfg_dwell = 24'($urandom);
          cfg_loop = 1'($urandom_range(0, 1)); cfg_dither = 1'($urandom_range(0, 1));
        end
        abort = (cyc == abort_at);
        cyc++;
        @(negedge aclk);
      end
      start = 1'b0;
      abort = 1'b0;
      checkOutput("run_ends", 32'(busy), 0);
      if (m_running) begin
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge aclk);
    end

    repeat (3) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
